// File: rtl/sh_unit_if.sv
// Handshake/bus bundle for sh_unit: command/load inputs from the master, register and status back.
interface sh_unit_if #(
    parameter int W  = 8,
    parameter int AW = $clog2(W + 1)
);
    logic          load;
    logic [W-1:0]  d;
    logic          start;
    logic [1:0]    mode;
    logic [AW-1:0] amt;
    logic          s_in;
    logic [W-1:0]  q;
    logic          s_out;
    logic          busy;
    logic          done;

    // Request semantics: load/start are single-cycle requests, accepted only when busy is low
    // at that edge; done pulses for exactly one cycle, during which the unit is already idle.
    modport master (
        output load, d, start, mode, amt, s_in,
        input  q, s_out, busy, done
    );

    modport slave (
        input  load, d, start, mode, amt, s_in,
        output q, s_out, busy, done
    );
endinterface

// File: rtl/sh_unit.sv
// Serial universal shift unit: parallel load plus LSR/LSL/ASR/ROR by N, one bit per clock.
module sh_unit #(
    parameter int W  = 8,
    parameter int AW = $clog2(W + 1)
) (
    input  logic     clk,
    input  logic     rst_n,
    sh_unit_if.slave bus,
    output logic     dbg_state_o
);
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

    localparam logic [1:0] M_LSR = 2'b00;
    localparam logic [1:0] M_LSL = 2'b01;
    localparam logic [1:0] M_ASR = 2'b10;

    state_e        state_q, state_d;
    logic [W-1:0]  q_q, q_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [1:0]    mode_q, mode_d;
    logic          s_out_q, s_out_d;
    logic          done_q, done_d;

    logic [AW-1:0] n;
    logic [1:0]    cur_mode;
    logic [W-1:0]  shifted;
    logic          out_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            mode_q  <= M_LSR;
            s_out_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            s_out_q <= s_out_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        n        = (bus.amt > AW'(W)) ? AW'(W) : bus.amt;
        // The first shift of a command uses the live mode; later shifts use the latched copy.
        cur_mode = (state_q == SHIFT) ? mode_q : bus.mode;
        shifted  = q_q;
        out_bit  = q_q[0];
        unique case (cur_mode)
            M_LSR:   shifted = {bus.s_in, q_q[W-1:1]};
            M_LSL: begin
                shifted = {q_q[W-2:0], bus.s_in};
                out_bit = q_q[W-1];
            end
            M_ASR:   shifted = {q_q[W-1], q_q[W-1:1]};
            default: shifted = {q_q[0], q_q[W-1:1]};
        endcase

        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        s_out_d = s_out_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.load) begin
                    q_d = bus.d;
                end else if (bus.start) begin
                    if (n == '0) begin
                        done_d = 1'b1;
                    end else begin
                        q_d     = shifted;
                        s_out_d = out_bit;
                        if (n == AW'(1)) begin
                            done_d = 1'b1;
                        end else begin
                            rem_d   = n - AW'(1);
                            mode_d  = bus.mode;
                            state_d = SHIFT;
                        end
                    end
                end
            end
            SHIFT: begin
                q_d     = shifted;
                s_out_d = out_bit;
                rem_d   = rem_q - AW'(1);
                if (rem_q == AW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.q       = q_q;
        bus.s_out   = s_out_q;
        bus.busy    = (state_q == SHIFT);
        bus.done    = done_q;
        dbg_state_o = state_q;
    end
endmodule

// File: tb/tb_sh_unit.sv
// Directed bench for sh_unit (W=8) with hand-computed expectations.
module tb_sh_unit;
    localparam int W  = 8;
    localparam int AW = $clog2(W + 1);

    logic clk;
    logic rst_n;
    logic dbg_state;
    int   checks;
    int   errors;
    int   busy_cnt;
    int   done_cnt;
    int   done_idx;

    sh_unit_if #(.W(W), .AW(AW)) bus ();

    sh_unit #(.W(W), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [W-1:0] val);
        bus.load = 1'b1;
        bus.d    = val;
        step();
        bus.load = 1'b0;
    endtask

    task automatic issue(input logic [1:0] m, input logic [AW-1:0] a, input logic si);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.amt   = a;
        bus.s_in  = si;
        step();
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        bus.amt   = '0;
    endtask

    // Issue a command and watch a fixed window (bounded wait) for busy and done.
    task automatic run_cmd(input logic [1:0] m, input logic [AW-1:0] a, input logic si);
        busy_cnt = 0;
        done_cnt = 0;
        done_idx = -1;
        issue(m, a, si);
        for (int i = 0; i < 12; i++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            step();
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.load  = 1'b1;
        bus.start = 1'b1;
        bus.d     = 8'hFF;
        bus.mode  = 2'b11;
        bus.amt   = 4'd3;
        bus.s_in  = 1'b1;
        step();
        step();
        chk("rst_q", bus.q, 8'h00);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_sout", bus.s_out, 1'b0);
        chk("rst_state", dbg_state, 1'b0);
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.s_in  = 1'b0;
        rst_n     = 1'b1;
        step();

        do_load(8'hB5);
        chk("load_q", bus.q, 8'hB5);
        run_cmd(2'b00, 4'd3, 1'b0);
        chk("lsr_q", bus.q, 8'h16);
        chk("lsr_sout", bus.s_out, 1'b1);
        chk("lsr_busy", busy_cnt, 2);
        chk("lsr_done_cnt", done_cnt, 1);
        chk("lsr_done_idx", done_idx, 2);

        do_load(8'h96);
        run_cmd(2'b10, 4'd4, 1'b0);
        chk("asr_q", bus.q, 8'hF9);
        chk("asr_sout", bus.s_out, 1'b0);
        chk("asr_done_idx", done_idx, 3);

        do_load(8'h81);
        run_cmd(2'b01, 4'd2, 1'b1);
        chk("lsl_q", bus.q, 8'h07);
        chk("lsl_sout", bus.s_out, 1'b0);

        do_load(8'hA5);
        run_cmd(2'b11, 4'd8, 1'b0);
        chk("ror8_q", bus.q, 8'hA5);
        chk("ror8_sout", bus.s_out, 1'b1);
        chk("ror8_busy", busy_cnt, 7);
        chk("ror8_done_cnt", done_cnt, 1);
        chk("ror8_done_idx", done_idx, 7);

        run_cmd(2'b11, 4'd12, 1'b0);
        chk("ror12_q", bus.q, 8'hA5);
        chk("ror12_busy", busy_cnt, 7);
        chk("ror12_done_idx", done_idx, 7);

        do_load(8'h3C);
        run_cmd(2'b00, 4'd0, 1'b1);
        chk("amt0_q", bus.q, 8'h3C);
        chk("amt0_sout", bus.s_out, 1'b1);
        chk("amt0_busy", busy_cnt, 0);
        chk("amt0_done_idx", done_idx, 0);
        chk("amt0_done_cnt", done_cnt, 1);

        run_cmd(2'b00, 4'd1, 1'b1);
        chk("amt1_q", bus.q, 8'h9E);
        chk("amt1_sout", bus.s_out, 1'b0);
        chk("amt1_busy", busy_cnt, 0);
        chk("amt1_done_idx", done_idx, 0);

        // Load and start together: load wins and no command runs.
        bus.load = 1'b1;
        bus.d    = 8'h55;
        run_cmd(2'b11, 4'd3, 1'b0);
        bus.load = 1'b0;
        chk("both_q", bus.q, 8'h55);
        chk("both_busy", busy_cnt, 0);
        chk("both_done", done_cnt, 0);

        // Requests while busy are ignored.
        do_load(8'h0F);
        issue(2'b01, 4'd4, 1'b0);
        chk("busy_q1", bus.q, 8'h1E);
        chk("busy_flag", bus.busy, 1'b1);
        chk("busy_state", dbg_state, 1'b1);
        bus.load  = 1'b1;
        bus.d     = 8'hFF;
        bus.start = 1'b1;
        bus.mode  = 2'b00;
        bus.amt   = 4'd1;
        step();
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.amt   = '0;
        chk("busy_q2", bus.q, 8'h3C);
        step();
        step();
        chk("busy_q_final", bus.q, 8'hF0);
        chk("busy_done", bus.done, 1'b1);
        chk("busy_idle", bus.busy, 1'b0);

        // Back-to-back: new start in the done cycle.
        issue(2'b00, 4'd2, 1'b0);
        chk("b2b_q1", bus.q, 8'h78);
        chk("b2b_busy", bus.busy, 1'b1);
        step();
        chk("b2b_q2", bus.q, 8'h3C);
        chk("b2b_done", bus.done, 1'b1);
        step();
        chk("b2b_done_end", bus.done, 1'b0);

        // Reset mid-command.
        do_load(8'hA5);
        issue(2'b11, 4'd8, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("mrst_q", bus.q, 8'h00);
        chk("mrst_busy", bus.busy, 1'b0);
        chk("mrst_done", bus.done, 1'b0);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done === 1'b1) done_cnt++;
            step();
        end
        chk("mrst_no_done", done_cnt, 0);
        chk("mrst_q_hold", bus.q, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
